// File: rtl/channel_fifo.sv
// Packet-commit FIFO: bytes are written speculatively and only become visible to
// the read side once the in-flight packet is committed; a flush rolls it back.
module channel_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_push,
    input  logic                  fifo_flush,
    input  logic                  fifo_wr_ptr_upd,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  fifo_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   used,
    output logic                  ovf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   cm_ptr_q, cm_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   wr_post;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  push_ok;
    logic                  pop;

    // Full counts uncommitted bytes; empty only sees committed ones.
    assign fifo_full = (wr_ptr_q - rd_ptr_q) == FULL_CNT;
    assign empty     = (rd_ptr_q == cm_ptr_q);
    assign used      = cm_ptr_q - rd_ptr_q;

    assign push_ok = fifo_push && !fifo_full && !fifo_flush;
    assign pop     = rd_en && !empty;
    assign wr_post = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push_ok};

    always_comb begin
        wr_ptr_d   = wr_post;
        cm_ptr_d   = cm_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;
        ovf_d      = fifo_push && fifo_full && !fifo_flush;
        if (fifo_flush) begin
            wr_ptr_d = cm_ptr_q;
        end else if (fifo_wr_ptr_upd) begin
            cm_ptr_d = wr_post;
        end
        if (pop) begin
            rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_channel_fifo.sv
// Directed bench for channel_fifo: committed bytes go into a scoreboard queue and
// a negedge monitor compares every rd_valid byte against it in order.
module tb_channel_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_push, fifo_flush, fifo_wr_ptr_upd, rd_en;
    logic [7:0] fifo_data_in;
    logic       fifo_full, rd_valid, empty, ovf;
    logic [7:0] rd_data;
    logic [4:0] used;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    channel_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .fifo_push(fifo_push), .fifo_flush(fifo_flush),
        .fifo_wr_ptr_upd(fifo_wr_ptr_upd), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .used(used), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs, then return all controls to idle.
    task automatic cyc(input logic p, input logic f, input logic u,
                       input logic [7:0] d, input logic r);
        fifo_push = p; fifo_flush = f; fifo_wr_ptr_upd = u;
        fifo_data_in = d; rd_en = r;
        @(posedge clk); #1;
        fifo_push = 0; fifo_flush = 0; fifo_wr_ptr_upd = 0; rd_en = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no data", rd_data);
            end else begin
                exp_b = sb.pop_front();
                if (rd_data !== exp_b) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, exp_b);
                end
            end
        end
    end

    initial begin
        fifo_push = 0; fifo_flush = 0; fifo_wr_ptr_upd = 0; rd_en = 0; fifo_data_in = 0;
        rst = 1'b1;
        #3;
        chk("rst_empty", empty, 1); chk("rst_full", fifo_full, 0);
        chk("rst_used", used, 0);   chk("rst_valid", rd_valid, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Commit of a 3-byte packet, upd on the last push
        cyc(1, 0, 0, 8'h11, 0);
        cyc(1, 0, 0, 8'h22, 0);
        chk("uncommitted_empty", empty, 1);
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        cyc(1, 0, 1, 8'h33, 0);
        chk("commit_empty", empty, 0);
        chk("commit_used", used, 3);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("drain_empty", empty, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rd_empty_valid", rd_valid, 0);
        chk("rd_empty_hold", rd_data, 8'h33);

        // Flush of an in-flight packet, then a fresh packet
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'hA0 + 8'(i), 0);
        cyc(0, 1, 0, 0, 0);
        chk("flush_empty", empty, 1); chk("flush_used", used, 0);
        chk("flush_full", fifo_full, 0);
        sb.push_back(8'hB0);
        cyc(1, 0, 1, 8'hB0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("flush_next_empty", empty, 1);

        // Fill 16 uncommitted, overflow, then push+pop while full
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'hC0 + 8'(i), 0);
        chk("fill_full", fifo_full, 1); chk("fill_ovf", ovf, 0);
        cyc(1, 0, 0, 8'hEE, 0);
        chk("ovf_pulse", ovf, 1); chk("ovf_used", used, 0);
        for (int i = 0; i < 16; i++) sb.push_back(8'hC0 + 8'(i));
        cyc(0, 0, 1, 0, 0);
        chk("ovf_clear", ovf, 0); chk("full_commit_used", used, 16);
        cyc(1, 0, 0, 8'hEF, 1);
        chk("pushpop_full_ovf", ovf, 1); chk("pushpop_used", used, 15);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("full_drain_empty", empty, 1); chk("full_drain_full", fifo_full, 0);
        chk("full_drain_used", used, 0);

        // Flush beats commit; no ovf on a flushed push
        cyc(1, 1, 1, 8'h55, 0);
        chk("fvc_used", used, 0); chk("fvc_empty", empty, 1); chk("fvc_ovf", ovf, 0);
        cyc(0, 0, 1, 0, 0);
        chk("noop_commit_used", used, 0);
        cyc(0, 1, 0, 0, 0);
        chk("noop_flush_empty", empty, 1);

        // Streamed single-byte packets with continuous reads (pointers wrap)
        for (int i = 0; i < 40; i++) begin
            sb.push_back(8'h40 + 8'(i));
            cyc(1, 0, 1, 8'h40 + 8'(i), 1);
            chk("stream_used_le2", 32'(used <= 5'd2), 1);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("stream_empty", empty, 1);
        chk("stream_sb_drained", sb.size(), 0);

        // Asynchronous reset while a packet is in flight
        cyc(1, 0, 0, 8'h77, 0);
        sb.push_back(8'h77); sb.push_back(8'h78);
        cyc(1, 0, 1, 8'h78, 0);
        cyc(1, 0, 0, 8'h01, 0);
        cyc(1, 0, 0, 8'h02, 0);
        cyc(1, 0, 0, 8'h03, 1);
        chk("pre_rst_valid", rd_valid, 1); chk("pre_rst_empty", empty, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1); chk("arst_full", fifo_full, 0);
        chk("arst_valid", rd_valid, 0); chk("arst_ovf", ovf, 0);
        chk("arst_used", used, 0);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        sb.push_back(8'h99);
        cyc(1, 0, 1, 8'h99, 0);
        chk("post_rst_used", used, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("final_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
